// File: rtl/mc_control_unit_pkg.sv
// Shared encodings for the multi-cycle control unit: ISA opcodes/funcs,
// ALU function codes, FSM states, instruction classes and mux selects.
package mc_control_unit_pkg;

  localparam int WORD_SIZE = 16;

  // Instruction opcodes (IR[15:12]); all R-type and special ops use OPCODE_ALU
  localparam logic [3:0] OPCODE_BNE = 4'd0;
  localparam logic [3:0] OPCODE_BEQ = 4'd1;
  localparam logic [3:0] OPCODE_BGZ = 4'd2;
  localparam logic [3:0] OPCODE_BLZ = 4'd3;
  localparam logic [3:0] OPCODE_ADI = 4'd4;
  localparam logic [3:0] OPCODE_ORI = 4'd5;
  localparam logic [3:0] OPCODE_LHI = 4'd6;
  localparam logic [3:0] OPCODE_LWD = 4'd7;
  localparam logic [3:0] OPCODE_SWD = 4'd8;
  localparam logic [3:0] OPCODE_JMP = 4'd9;
  localparam logic [3:0] OPCODE_JAL = 4'd10;
  localparam logic [3:0] OPCODE_ALU = 4'd15;

  // Function field (IR[5:0]) under OPCODE_ALU
  localparam logic [5:0] INST_FUNC_ADD = 6'd0;
  localparam logic [5:0] INST_FUNC_SHR = 6'd7;
  localparam logic [5:0] INST_FUNC_JPR = 6'd25;
  localparam logic [5:0] INST_FUNC_JRL = 6'd26;
  localparam logic [5:0] INST_FUNC_WWD = 6'd28;
  localparam logic [5:0] INST_FUNC_HLT = 6'd29;

  // ALU function codes; R-type ALU ops 0..7 map one-to-one onto func 0..7
  localparam logic [3:0] FUNC_ADD = 4'd0;
  localparam logic [3:0] FUNC_SUB = 4'd1;
  localparam logic [3:0] FUNC_AND = 4'd2;
  localparam logic [3:0] FUNC_ORR = 4'd3;
  localparam logic [3:0] FUNC_NOT = 4'd4;
  localparam logic [3:0] FUNC_TCP = 4'd5;
  localparam logic [3:0] FUNC_SHL = 4'd6;
  localparam logic [3:0] FUNC_SHR = 4'd7;
  localparam logic [3:0] FUNC_LHI = 4'd8;
  localparam logic [3:0] FUNC_BNE = 4'd9;
  localparam logic [3:0] FUNC_BEQ = 4'd10;
  localparam logic [3:0] FUNC_BGZ = 4'd11;
  localparam logic [3:0] FUNC_BLZ = 4'd12;
  localparam logic [3:0] FUNC_JMP = 4'd13;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_BR   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    CLS_NOP, CLS_RALU, CLS_ADI, CLS_ORI, CLS_LHI, CLS_LWD, CLS_SWD,
    CLS_BR, CLS_JMP, CLS_JAL, CLS_JPR, CLS_JRL, CLS_WWD, CLS_HLT
  } iclass_t;

  // Datapath mux selects
  localparam logic       SRC_A_PC     = 1'b0;
  localparam logic       SRC_A_REG    = 1'b1;
  localparam logic [1:0] SRC_B_REG    = 2'd0;
  localparam logic [1:0] SRC_B_ONE    = 2'd1;
  localparam logic [1:0] SRC_B_SEXT   = 2'd2;
  localparam logic [1:0] SRC_B_ZEXT   = 2'd3;
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_REG    = 2'd2;
  localparam logic [1:0] WB_ALUOUT    = 2'd0;
  localparam logic [1:0] WB_MDR       = 2'd1;
  localparam logic [1:0] WB_PC        = 2'd2;
  localparam logic [1:0] DST_RT       = 2'd0;
  localparam logic [1:0] DST_RD       = 2'd1;
  localparam logic [1:0] DST_R2       = 2'd2;

endpackage

// File: rtl/mc_decoder.sv
// Combinational instruction decoder: opcode/func -> instruction class and ALU function.
module mc_decoder
  import mc_control_unit_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [5:0] func,
  output iclass_t    cls,
  output logic [3:0] alu_func
);

  // Classify the instruction; anything not recognised decodes as a NOP
  always_comb begin
    cls      = CLS_NOP;
    alu_func = FUNC_ADD;
    case (opcode)
      OPCODE_ALU: begin
        if (func <= INST_FUNC_SHR) begin
          cls      = CLS_RALU;
          alu_func = func[3:0];
        end else if (func == INST_FUNC_JPR) begin
          cls = CLS_JPR;
        end else if (func == INST_FUNC_JRL) begin
          cls = CLS_JRL;
        end else if (func == INST_FUNC_WWD) begin
          cls = CLS_WWD;
        end else if (func == INST_FUNC_HLT) begin
          cls = CLS_HLT;
        end
      end
      OPCODE_ADI: cls = CLS_ADI;
      OPCODE_ORI: begin cls = CLS_ORI; alu_func = FUNC_ORR; end
      OPCODE_LHI: begin cls = CLS_LHI; alu_func = FUNC_LHI; end
      OPCODE_LWD: cls = CLS_LWD;
      OPCODE_SWD: cls = CLS_SWD;
      OPCODE_BNE: begin cls = CLS_BR; alu_func = FUNC_BNE; end
      OPCODE_BEQ: begin cls = CLS_BR; alu_func = FUNC_BEQ; end
      OPCODE_BGZ: begin cls = CLS_BR; alu_func = FUNC_BGZ; end
      OPCODE_BLZ: begin cls = CLS_BR; alu_func = FUNC_BLZ; end
      OPCODE_JMP: begin cls = CLS_JMP; alu_func = FUNC_JMP; end
      OPCODE_JAL: begin cls = CLS_JAL; alu_func = FUNC_JMP; end
      default:    cls = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM for the shared 16-bit datapath. Strobes are decoded
// from the current state and IR fields; only the state, branch flag, memory
// wait counter and retired-instruction count are registered.
module mc_control_unit
  import mc_control_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  opcode,
  input  logic [5:0]  func,
  input  logic        b_cond,
  input  logic        mem_ack,
  output logic        mem_read,
  output logic        mem_write,
  output logic        i_or_d,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wb_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_func,
  output logic [1:0]  pc_source,
  output logic        output_en,
  output logic        is_halted,
  output logic [15:0] num_inst
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        flag_q, flag_d;
  logic [15:0] num_inst_q, num_inst_d;
  logic [15:0] wait_q, wait_d;
  logic        retire;
  logic        mem_expired;
  iclass_t     cls;
  logic [3:0]  dec_func;

  mc_decoder u_dec (
    .opcode   (opcode),
    .func     (func),
    .cls      (cls),
    .alu_func (dec_func)
  );

  assign mem_expired = (MEM_TIMEOUT != 0) && (wait_q == TIMEOUT_LAST);
  assign num_inst    = num_inst_q;

  // Next state and per-state strobes; everything is held at its reset value while reset is high
  always_comb begin
    state_d   = state_q;
    flag_d    = flag_q;
    wait_d    = '0;
    retire    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    i_or_d    = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    reg_dst   = DST_RT;
    wb_src    = WB_ALUOUT;
    alu_src_a = SRC_A_PC;
    alu_src_b = SRC_B_REG;
    alu_func  = FUNC_ADD;
    pc_source = PCSRC_ALU;
    output_en = 1'b0;
    is_halted = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IF: begin
          mem_read = 1'b1;
          if (mem_ack) begin
            ir_write = 1'b1;
            state_d  = S_ID;
          end else if (mem_expired) begin
            state_d = S_HALT;
          end else begin
            wait_d = wait_q + 16'd1;
          end
        end
        S_ID: begin
          alu_src_a = SRC_A_PC;
          alu_src_b = SRC_B_ONE;
          pc_source = PCSRC_ALU;
          pc_write  = 1'b1;
          case (cls)
            CLS_HLT: state_d = S_HALT;
            CLS_WWD: begin output_en = 1'b1; retire = 1'b1; state_d = S_IF; end
            CLS_NOP: begin retire = 1'b1; state_d = S_IF; end
            default: state_d = S_EX;
          endcase
        end
        S_EX: begin
          case (cls)
            CLS_RALU: begin
              alu_src_a = SRC_A_REG; alu_src_b = SRC_B_REG; alu_func = dec_func; state_d = S_WB;
            end
            CLS_ADI: begin
              alu_src_a = SRC_A_REG; alu_src_b = SRC_B_SEXT; alu_func = dec_func; state_d = S_WB;
            end
            CLS_ORI, CLS_LHI: begin
              alu_src_a = SRC_A_REG; alu_src_b = SRC_B_ZEXT; alu_func = dec_func; state_d = S_WB;
            end
            CLS_LWD, CLS_SWD: begin
              alu_src_a = SRC_A_REG; alu_src_b = SRC_B_SEXT; alu_func = FUNC_ADD; state_d = S_MEM;
            end
            CLS_BR: begin
              alu_src_a = SRC_A_REG; alu_src_b = SRC_B_REG; alu_func = dec_func;
              flag_d    = b_cond;
              state_d   = S_BR;
            end
            CLS_JMP, CLS_JAL: begin
              alu_func  = FUNC_JMP; alu_src_a = SRC_A_PC; alu_src_b = SRC_B_SEXT;
              pc_write  = 1'b1; retire = 1'b1; state_d = S_IF;
              // PC already holds PC+1, so the link value is simply the PC
              if (cls == CLS_JAL) begin
                reg_write = 1'b1; reg_dst = DST_R2; wb_src = WB_PC;
              end
            end
            CLS_JPR, CLS_JRL: begin
              pc_source = PCSRC_REG; pc_write = 1'b1; retire = 1'b1; state_d = S_IF;
              if (cls == CLS_JRL) begin
                reg_write = 1'b1; reg_dst = DST_R2; wb_src = WB_PC;
              end
            end
            default: begin retire = 1'b1; state_d = S_IF; end
          endcase
        end
        S_BR: begin
          alu_func  = FUNC_ADD;
          alu_src_a = SRC_A_PC;
          alu_src_b = SRC_B_SEXT;
          pc_source = PCSRC_ALU;
          pc_write  = flag_q;
          retire    = 1'b1;
          state_d   = S_IF;
        end
        S_MEM: begin
          i_or_d = 1'b1;
          if (cls == CLS_LWD) mem_read = 1'b1;
          else                mem_write = 1'b1;
          if (mem_ack) begin
            if (cls == CLS_LWD) begin
              state_d = S_WB;
            end else begin
              retire  = 1'b1;
              state_d = S_IF;
            end
          end else if (mem_expired) begin
            state_d = S_HALT;
          end else begin
            wait_d = wait_q + 16'd1;
          end
        end
        S_WB: begin
          reg_write = 1'b1;
          wb_src    = (cls == CLS_LWD)  ? WB_MDR : WB_ALUOUT;
          reg_dst   = (cls == CLS_RALU) ? DST_RD : DST_RT;
          retire    = 1'b1;
          state_d   = S_IF;
        end
        S_HALT: is_halted = 1'b1;
        default: state_d = S_IF;
      endcase
    end
  end

  // Retired-instruction counter wraps naturally at 16 bits
  always_comb begin
    num_inst_d = retire ? num_inst_q + 16'd1 : num_inst_q;
  end

  // State, branch flag, wait counter and instruction count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IF;
      flag_q     <= 1'b0;
      num_inst_q <= '0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      flag_q     <= flag_d;
      num_inst_q <= num_inst_d;
      wait_q     <= wait_d;
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: walks instruction sequences cycle by
// cycle and compares strobes against hand-derived expectations.
module tb_mc_control_unit;
  import mc_control_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  opcode;
  logic [5:0]  func;
  logic        b_cond;
  logic        mem_ack;
  logic        mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write;
  logic [1:0]  reg_dst, wb_src, alu_src_b, pc_source;
  logic        alu_src_a, output_en, is_halted;
  logic [3:0]  alu_func;
  logic [15:0] num_inst;

  int n_tests = 0;
  int n_fail  = 0;

  mc_control_unit dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .func      (func),
    .b_cond    (b_cond),
    .mem_ack   (mem_ack),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .i_or_d    (i_or_d),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .reg_write (reg_write),
    .reg_dst   (reg_dst),
    .wb_src    (wb_src),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .alu_func  (alu_func),
    .pc_source (pc_source),
    .output_en (output_en),
    .is_halted (is_halted),
    .num_inst  (num_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, got, want);
    end
  endtask

  // Advance one cycle: inputs change at the falling edge, outputs sampled 1ns later
  task automatic step(input logic ack, input logic bc);
    @(negedge clk);
    mem_ack = ack;
    b_cond  = bc;
    #1;
  endtask

  // Start an instruction from the current S_IF cycle with a 0-wait fetch
  task automatic fetch(input logic [3:0] op, input logic [5:0] fn);
    opcode  = op;
    func    = fn;
    mem_ack = 1'b1;
    #1;
    chk("fetch_ir_write", 16'(ir_write), 16'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; opcode = '0; func = '0; b_cond = 1'b0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_read", 16'(mem_read), 16'd0);
    chk("rst_alu_func", 16'(alu_func), 16'(FUNC_ADD));
    chk("rst_num_inst", num_inst, 16'd0);
    chk("rst_halted",   16'(is_halted), 16'd0);

    // 1: reset dropped asynchronously in the middle of a fetch
    @(negedge clk); reset = 1'b0; #1;
    chk("if_mem_read", 16'(mem_read), 16'd1);
    chk("if_i_or_d",   16'(i_or_d),   16'd0);
    #2 reset = 1'b1; #1;
    chk("async_drop_mem_read", 16'(mem_read), 16'd0);
    @(negedge clk); reset = 1'b0; #1;
    chk("post_rst_mem_read", 16'(mem_read), 16'd1);
    chk("post_rst_num",      num_inst, 16'd0);

    // 2: ADD $3,$1,$2 (stray mem_ack in S_ID must be ignored)
    fetch(OPCODE_ALU, INST_FUNC_ADD);
    step(1'b1, 1'b0);
    chk("add_id_pc_write", 16'(pc_write), 16'd1);
    chk("add_id_src_b",    16'(alu_src_b), 16'(SRC_B_ONE));
    chk("add_id_mem_read", 16'(mem_read), 16'd0);
    step(1'b0, 1'b0);
    chk("add_ex_src_a",    16'(alu_src_a), 16'd1);
    chk("add_ex_func",     16'(alu_func), 16'(FUNC_ADD));
    chk("add_ex_reg_write", 16'(reg_write), 16'd0);
    step(1'b0, 1'b0);
    chk("add_wb_reg_write", 16'(reg_write), 16'd1);
    chk("add_wb_reg_dst",   16'(reg_dst), 16'(DST_RD));
    chk("add_wb_num",       num_inst, 16'd0);
    step(1'b0, 1'b0);
    chk("add_num",      num_inst, 16'd1);
    chk("add_back_if",  16'(mem_read), 16'd1);

    // 3: LWD with 3 wait cycles on both fetch and data access
    opcode = OPCODE_LWD; func = '0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step(i == 3, 1'b0);
      chk("lwd_if_mem_read", 16'(mem_read), 16'd1);
      chk("lwd_if_ir_write", 16'(ir_write), 16'(i == 3));
    end
    step(1'b0, 1'b0);
    chk("lwd_id_pc_write", 16'(pc_write), 16'd1);
    step(1'b0, 1'b0);
    chk("lwd_ex_src_b", 16'(alu_src_b), 16'(SRC_B_SEXT));
    for (int i = 0; i < 4; i++) begin
      step(i == 3, 1'b0);
      chk("lwd_mem_read",  16'(mem_read), 16'd1);
      chk("lwd_mem_i_or_d", 16'(i_or_d), 16'd1);
      chk("lwd_mem_reg_write", 16'(reg_write), 16'd0);
    end
    step(1'b0, 1'b0);
    chk("lwd_wb_reg_write", 16'(reg_write), 16'd1);
    chk("lwd_wb_src",       16'(wb_src), 16'(WB_MDR));
    chk("lwd_wb_reg_dst",   16'(reg_dst), 16'(DST_RT));
    step(1'b0, 1'b0);
    chk("lwd_num", num_inst, 16'd2);

    // 4: BEQ taken, then BNE not taken (b_cond raised in S_BR must not matter)
    fetch(OPCODE_BEQ, '0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("beq_ex_func",     16'(alu_func), 16'(FUNC_BEQ));
    chk("beq_ex_pc_write", 16'(pc_write), 16'd0);
    step(1'b0, 1'b0);
    chk("beq_br_pc_write", 16'(pc_write), 16'd1);
    chk("beq_br_src_b",    16'(alu_src_b), 16'(SRC_B_SEXT));
    step(1'b0, 1'b0);
    chk("beq_num", num_inst, 16'd3);
    fetch(OPCODE_BNE, '0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("bne_ex_func", 16'(alu_func), 16'(FUNC_BNE));
    step(1'b0, 1'b1);
    chk("bne_br_pc_write", 16'(pc_write), 16'd0);
    step(1'b0, 1'b0);
    chk("bne_num", num_inst, 16'd4);

    // 5: JAL, JPR, WWD, undefined opcode, ORI, SWD
    fetch(OPCODE_JAL, '0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("jal_pc_write",  16'(pc_write), 16'd1);
    chk("jal_reg_write", 16'(reg_write), 16'd1);
    chk("jal_reg_dst",   16'(reg_dst), 16'(DST_R2));
    chk("jal_wb_src",    16'(wb_src), 16'(WB_PC));
    chk("jal_func",      16'(alu_func), 16'(FUNC_JMP));
    step(1'b0, 1'b0);
    chk("jal_next_if", 16'(mem_read), 16'd1);
    chk("jal_num",     num_inst, 16'd5);

    fetch(OPCODE_ALU, INST_FUNC_JPR);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("jpr_pc_source", 16'(pc_source), 16'(PCSRC_REG));
    chk("jpr_reg_write", 16'(reg_write), 16'd0);
    step(1'b0, 1'b0);
    chk("jpr_num", num_inst, 16'd6);

    fetch(OPCODE_ALU, INST_FUNC_WWD);
    step(1'b0, 1'b0);
    chk("wwd_output_en", 16'(output_en), 16'd1);
    step(1'b0, 1'b0);
    chk("wwd_next_if", 16'({mem_read, output_en}), 16'b10);
    chk("wwd_num", num_inst, 16'd7);

    fetch(4'd12, '0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("nop_next_if", 16'(mem_read), 16'd1);
    chk("nop_num", num_inst, 16'd8);

    fetch(OPCODE_ORI, '0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("ori_ex_src_b", 16'(alu_src_b), 16'(SRC_B_ZEXT));
    chk("ori_ex_func",  16'(alu_func), 16'(FUNC_ORR));
    step(1'b0, 1'b0);
    chk("ori_wb", 16'({reg_write, reg_dst, wb_src}), 16'b1_00_00);
    step(1'b0, 1'b0);
    chk("ori_num", num_inst, 16'd9);

    fetch(OPCODE_SWD, '0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("swd_mem", 16'({mem_write, mem_read, i_or_d}), 16'b101);
    step(1'b1, 1'b0);
    chk("swd_mem_ack", 16'(mem_write), 16'd1);
    chk("swd_num_before", num_inst, 16'd9);
    step(1'b0, 1'b0);
    chk("swd_num", num_inst, 16'd10);

    // 6: HLT absorbs mem_ack pulses; counter holds a preloaded 16'hFFFF
    fetch(OPCODE_ALU, INST_FUNC_HLT);
    step(1'b0, 1'b0);
    chk("hlt_id_halted", 16'(is_halted), 16'd0);
    step(1'b0, 1'b0);
    chk("hlt_halted", 16'(is_halted), 16'd1);
    force dut.num_inst_q = 16'hFFFF;
    #1;
    release dut.num_inst_q;
    #1;
    for (int i = 0; i < 20; i++) begin
      step(i[0], 1'b0);
      chk("halt_is_halted", 16'(is_halted), 16'd1);
      chk("halt_strobes", 16'({mem_read, mem_write, ir_write, pc_write, reg_write, output_en}), 16'd0);
      chk("halt_num", num_inst, 16'hFFFF);
    end
    mem_ack = 1'b0;
    reset = 1'b1; #1;
    chk("halt_rst_released", 16'(is_halted), 16'd0);
    @(negedge clk); reset = 1'b0; #1;
    chk("halt_rst_num", num_inst, 16'd0);
    force dut.num_inst_q = 16'hFFFF;
    #1;
    release dut.num_inst_q;
    fetch(OPCODE_JMP, '0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("jmp_ex", 16'({pc_write, alu_func}), 16'({1'b1, FUNC_JMP}));
    chk("jmp_num_pre_wrap", num_inst, 16'hFFFF);
    step(1'b0, 1'b0);
    chk("jmp_num_wrap", num_inst, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
